if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register.
- Sits directly upstream of the decode stage. Consumes pc_write / if_id_write / if_id_flush from the hazard detection unit.
- Consumes redirect information (branch, jump, jr, eret, interrupt entry) and drives the instruction-memory address.
- Presents instr_id / pc_plus4_id to decode, together with a valid bit and a fetch counter.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/if_stage_if.sv | 19 +
 rtl/if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 85 ++++++++
 tb/tb_if_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Constants and helpers shared by the MIPS pipeline stages, the hazard unit and the decoder.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] INT_VECTOR   = 32'h0000_0800;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  // Which source feeds the next PC; also useful as a debug probe.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_ERET   = 3'd4,
    SEL_INT    = 3'd5
  } pc_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus plus the IF/ID outputs presented to decode.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, instr_id, pc_plus4_id, valid_id, fetch_count,
    input  imem_data
  );

  modport slave (
    input  imem_addr, instr_id, pc_plus4_id, valid_id, fetch_count,
    output imem_data
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble and dominates write; stall holds everything.
module if_id_reg
  import mips_pkg::pc_sel_e;
#(
  parameter logic [31:0] NOP = mips_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
      count    <= 32'h0;
    end else if (flush) begin
      instr    <= NOP;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b0;
    end else if (write) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
      count    <= count + 32'd1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, prioritised next-PC selection and the IF/ID register.
module if_stage
  import mips_pkg::pc_sel_e, mips_pkg::word_align;
  import mips_pkg::SEL_SEQ, mips_pkg::SEL_BRANCH, mips_pkg::SEL_JUMP;
  import mips_pkg::SEL_JR, mips_pkg::SEL_ERET, mips_pkg::SEL_INT;
#(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
  parameter logic [31:0] INT_VECTOR   = mips_pkg::INT_VECTOR,
  parameter logic [31:0] NOP          = mips_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        if_id_flush,
  input  logic        inta,
  input  logic        eret_id,
  input  logic [31:0] epc,
  input  logic        branch_taken_id,
  input  logic [31:0] branch_target_id,
  input  logic        jump_id,
  input  logic [31:0] jump_target_id,
  input  logic        jr_id,
  input  logic [31:0] jr_target_id,
  if_stage_if.master  bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_raw;
  logic [31:0] next_pc;
  pc_sel_e     pc_sel;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_sel = SEL_SEQ;
    if (inta)                 pc_sel = SEL_INT;
    else if (eret_id)         pc_sel = SEL_ERET;
    else if (jr_id)           pc_sel = SEL_JR;
    else if (jump_id)         pc_sel = SEL_JUMP;
    else if (branch_taken_id) pc_sel = SEL_BRANCH;
  end

  always_comb begin
    next_raw = pc_plus4;
    case (pc_sel)
      SEL_INT:    next_raw = INT_VECTOR;
      SEL_ERET:   next_raw = epc;
      SEL_JR:     next_raw = jr_target_id;
      SEL_JUMP:   next_raw = jump_target_id;
      SEL_BRANCH: next_raw = branch_target_id;
      default:    next_raw = pc_plus4;
    endcase
  end

  assign next_pc = word_align(next_raw);

  // An interrupt acknowledge must land even while the hazard unit is stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else if (pc_write || inta) begin
      pc_q <= next_pc;
    end
  end

  assign bus.imem_addr = pc_q;

  if_id_reg #(
    .NOP (NOP)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .write       (if_id_write),
    .flush       (if_id_flush | inta),
    .instr_in    (bus.imem_data),
    .pc_plus4_in (pc_plus4),
    .instr       (bus.instr_id),
    .pc_plus4    (bus.pc_plus4_id),
    .valid       (bus.valid_id),
    .count       (bus.fetch_count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomised bench for if_stage with a reference model and expected queue.
module tb_if_stage;

  localparam int W = 129;
  localparam logic [31:0] NOP_W = 32'h0000_0000;
  localparam logic [31:0] INT_V = 32'h0000_0800;

  logic        clk;
  logic        rst_n;
  logic        pc_write, if_id_write, if_id_flush, inta;
  logic        eret_id, branch_taken_id, jump_id, jr_id;
  logic [31:0] epc, branch_target_id, jump_target_id, jr_target_id;

  if_stage_if bus ();

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .inta             (inta),
    .eret_id          (eret_id),
    .epc              (epc),
    .branch_taken_id  (branch_taken_id),
    .branch_target_id (branch_target_id),
    .jump_id          (jump_id),
    .jump_target_id   (jump_target_id),
    .jr_id            (jr_id),
    .jr_target_id     (jr_target_id),
    .bus              (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state: {pc, instr, pc_plus4, valid, count}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e);
    check({tag, ".imem_addr"},   bus.imem_addr,           e[128:97]);
    check({tag, ".instr_id"},    bus.instr_id,            e[96:65]);
    check({tag, ".pc_plus4_id"}, bus.pc_plus4_id,         e[64:33]);
    check({tag, ".valid_id"},    {31'h0, bus.valid_id},   {31'h0, e[32]});
    check({tag, ".fetch_count"}, bus.fetch_count,         e[31:0]);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP_W; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  // driver tasks
  task automatic idle();
    pc_write = 1'b1; if_id_write = 1'b1; if_id_flush = 1'b0; inta = 1'b0;
    eret_id = 1'b0; branch_taken_id = 1'b0; jump_id = 1'b0; jr_id = 1'b0;
  endtask

  task automatic step(input string tag);
    logic [31:0]  npc;
    logic [W-1:0] e;
    if (inta)                 npc = INT_V;
    else if (eret_id)         npc = epc;
    else if (jr_id)           npc = jr_target_id;
    else if (jump_id)         npc = jump_target_id;
    else if (branch_taken_id) npc = branch_target_id;
    else                      npc = m_pc + 32'd4;
    npc[1:0] = 2'b00;
    if (if_id_flush || inta) begin
      m_instr = NOP_W; m_pc4 = m_pc + 32'd4; m_valid = 1'b0;
    end else if (if_id_write) begin
      m_instr = bus.imem_data; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
    end
    if (pc_write || inta) m_pc = npc;
    exp_q.push_back({m_pc, m_instr, m_pc4, m_valid, m_cnt});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_all(tag, e);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    epc = 32'h0; branch_target_id = 32'h0; jump_target_id = 32'h0; jr_target_id = 32'h0;
    bus.imem_data = 32'h2008_0005;
    model_reset();
    #1;
    check_all("reset", {32'h0, NOP_W, 32'h0, 1'b0, 32'h0});
    #1 rst_n = 1'b1;

    // sequential fetch from the reset vector
    step("seq0");
    step("seq1");
    step("seq2");
    step("seq3");

    // stall at pc=0x10
    pc_write = 1'b0; if_id_write = 1'b0;
    bus.imem_data = 32'h8C09_0004;
    step("stall0");
    step("stall1");
    idle();
    step("resume");

    // taken branch at pc=0x14 with wrong-path squash
    branch_taken_id = 1'b1; branch_target_id = 32'h0000_0040; if_id_flush = 1'b1;
    step("branch");
    idle();
    step("after_branch");

    // several redirects at once: jr wins, low bits dropped
    jr_id = 1'b1; jr_target_id = 32'h0000_0103;
    jump_id = 1'b1; jump_target_id = 32'h0000_0200;
    branch_taken_id = 1'b1; branch_target_id = 32'h0000_0300; if_id_flush = 1'b1;
    step("multi_redirect");

    // redirect during stall is dropped
    idle();
    pc_write = 1'b0; if_id_write = 1'b0; jump_id = 1'b1; jump_target_id = 32'h0000_0500;
    step("stall_jump");

    // interrupt overrides stall and jump
    inta = 1'b1;
    step("inta");
    idle();
    step("after_inta");

    // eret back to epc
    eret_id = 1'b1; epc = 32'h0000_0018; if_id_flush = 1'b1;
    step("eret");
    idle();
    step("after_eret");

    // pc wraps past 0xFFFF_FFFC
    jump_id = 1'b1; jump_target_id = 32'hFFFF_FFFC; if_id_flush = 1'b1;
    step("jump_top");
    idle();
    bus.imem_data = 32'h1234_5678;
    step("wrap");

    // randomised control mix
    for (int i = 0; i < 24; i++) begin
      pc_write         = ($urandom_range(0, 3) != 0);
      if_id_write      = ($urandom_range(0, 3) != 0);
      if_id_flush      = ($urandom_range(0, 3) == 0);
      inta             = ($urandom_range(0, 7) == 0);
      eret_id          = ($urandom_range(0, 5) == 0);
      jr_id            = ($urandom_range(0, 5) == 0);
      jump_id          = ($urandom_range(0, 5) == 0);
      branch_taken_id  = ($urandom_range(0, 3) == 0);
      epc              = $urandom;
      jr_target_id     = $urandom;
      jump_target_id   = $urandom;
      branch_target_id = $urandom;
      bus.imem_data    = $urandom;
      step("rand");
    end

    // asynchronous reset mid-cycle during a stall
    idle();
    pc_write = 1'b0; if_id_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", {32'h0, NOP_W, 32'h0, 1'b0, 32'h0});
    model_reset();
    #1 rst_n = 1'b1;
    idle();
    bus.imem_data = 32'h2008_0005;
    step("post_rst");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
